// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and lane helpers for the byte-enable data memory
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_B:    return 4'b0001 << lane;
            SZ_H:    return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic access_error(input logic [1:0] size, input logic [1:0] lane);
        return (size == SZ_X) || (size == SZ_H && lane[0]) || (size == SZ_W && lane != 2'b00);
    endfunction

    // Store data is right-aligned on the bus; replicate it so any enabled lane sees its byte.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic is_unsigned);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_B:    return is_unsigned ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    return is_unsigned ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_array.sv
// rtl/dmem_lane_array.sv - word-addressed storage built from four independently written byte lanes
module dmem_lane_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [3:0]            we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] rd_q;

        // Read returns the pre-write value on a same-address write edge.
        always_ff @(posedge clk) begin
            if (we[l]) begin
                lane_mem[addr] <= wdata[8*l +: 8];
            end
            rd_q <= lane_mem[addr];
        end

        assign rdata[8*l +: 8] = rd_q;
    end

endmodule

// File: rtl/dmem_be_ctrl.sv
// rtl/dmem_be_ctrl.sv - valid/ready data memory with byte/half/word access, wait states and error flagging
module dmem_be_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int ADDR_W      = DEPTH_LOG2 + 2,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t              state;
    state_t              state_next;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                we_q;
    logic                uns_q;
    logic [31:0]         wdata_q;
    logic                accept;
    logic                req_bad;
    logic                access;
    logic [DEPTH_LOG2-1:0] arr_addr;
    logic [3:0]          arr_we;
    logic [31:0]         arr_wdata;
    logic [31:0]         arr_rdata;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;
    assign req_bad   = access_error(req_size, req_addr[1:0]);
    assign access    = (state == ST_WAIT) && (cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = req_bad ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            addr_q    <= '0;
            size_q    <= SZ_B;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            wdata_q   <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            cnt       <= WS;
            addr_q    <= req_addr;
            size_q    <= req_size;
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            wdata_q   <= req_wdata;
            rsp_rdata <= 32'h0;
            rsp_err   <= req_bad;
        end else if (state == ST_WAIT) begin
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else if (!we_q) begin
                rsp_rdata <= load_extend(arr_rdata, size_q, addr_q[1:0], uns_q);
            end
        end
    end

    // In IDLE the array tracks the incoming address so the word is already read by the first WAIT cycle.
    assign arr_addr  = req_ready ? req_addr[ADDR_W-1:2] : addr_q[ADDR_W-1:2];
    assign arr_we    = (access && we_q) ? lane_enable(size_q, addr_q[1:0]) : 4'b0000;
    assign arr_wdata = store_data(size_q, wdata_q);

    dmem_lane_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .addr  (arr_addr),
        .we    (arr_we),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_be_ctrl.sv
// tb/tb_dmem_be_ctrl.sv - scoreboard bench for dmem_be_ctrl with WAIT_STATES=2 and WAIT_STATES=0 instances
module tb_dmem_be_ctrl;
    import dmem_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [11:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic [31:0] rsp_rdata    [2];
    logic        rsp_err      [2];
    logic        prev_valid   [2];

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_be_ctrl #(.DEPTH_LOG2(10), .WAIT_STATES(2)) u_dut_ws2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    dmem_be_ctrl #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the oldest expectation whenever a DUT pulses rsp_valid.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid[d] === 1'b1) begin
                have = 1'b0;
                if (d == 0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    have = 1'b1;
                end else if (d == 1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    have = 1'b1;
                end
                if (!have) begin
                    check($sformatf("unexpected_rsp_dut%0d", d), 32'd1, 32'd0);
                end else begin
                    check($sformatf("rdata_dut%0d", d), rsp_rdata[d], e.rdata);
                    check($sformatf("err_dut%0d", d), 32'(rsp_err[d]), 32'(e.err));
                    check($sformatf("latency_dut%0d", d), 32'(cyc - e.acc), 32'(e.lat));
                end
                if (prev_valid[d] === 1'b1) begin
                    check($sformatf("rsp_pulse_width_dut%0d", d), 32'd2, 32'd1);
                end
            end
            prev_valid[d] = rsp_valid[d];
        end
    end

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check($sformatf("ready_timeout_dut%0d", d), 32'(req_ready[d]), 32'd1);
    endtask

    task automatic req(input int d, input logic we, input logic [1:0] size, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input bit hold);
        exp_t e;
        int   lat;
        lat = exp_err ? 1 : ((d == 0) ? 4 : 2);
        wait_ready(d);
        req_we[d]       = we;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wdata;
        req_valid[d]    = 1'b1;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.acc   = cyc;
        e.lat   = lat;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(negedge clk);
        check($sformatf("busy_ready_dut%0d", d), 32'(req_ready[d]), 32'd0);
        if (hold && lat > 1) begin
            req_we[d]    = ~we;
            req_addr[d]  = addr ^ 12'h004;
            req_wdata[d] = 32'h5555AAAA;
            repeat (lat - 1) @(negedge clk);
        end
        req_valid[d] = 1'b0;
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = SZ_W; req_unsigned[d] = 1'b0;
            req_addr[d] = 12'h0; req_wdata[d] = 32'h0; prev_valid[d] = 1'b0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_ready_dut%0d", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("reset_rsp_valid_dut%0d", d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("reset_rdata_dut%0d", d), rsp_rdata[d], 32'h0);
            check($sformatf("reset_err_dut%0d", d), 32'(rsp_err[d]), 32'd0);
        end
        rst_n = 1'b1;

        // WAIT_STATES=2: word store/load with req_valid held while busy
        req(0, 1'b1, SZ_W, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        req(0, 1'b0, SZ_W, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        req(0, 1'b1, SZ_B, 1'b0, 12'h013, 32'h0000007F, 32'h0, 1'b0, 1'b0);
        req(0, 1'b0, SZ_W, 1'b0, 12'h010, 32'h0, 32'h7FADBEEF, 1'b0, 1'b0);
        req(0, 1'b0, SZ_B, 1'b0, 12'h013, 32'h0, 32'h0000007F, 1'b0, 1'b0);
        req(0, 1'b0, SZ_B, 1'b0, 12'h012, 32'h0, 32'hFFFFFFAD, 1'b0, 1'b0);
        req(0, 1'b0, SZ_B, 1'b1, 12'h012, 32'h0, 32'h000000AD, 1'b0, 1'b0);
        req(0, 1'b0, SZ_H, 1'b0, 12'h010, 32'h0, 32'hFFFFBEEF, 1'b0, 1'b0);
        req(0, 1'b0, SZ_H, 1'b1, 12'h010, 32'h0, 32'h0000BEEF, 1'b0, 1'b0);
        req(0, 1'b0, SZ_H, 1'b0, 12'h012, 32'h0, 32'h00007FAD, 1'b0, 1'b0);
        req(0, 1'b1, SZ_H, 1'b0, 12'h012, 32'h00008001, 32'h0, 1'b0, 1'b0);
        req(0, 1'b0, SZ_W, 1'b0, 12'h010, 32'h0, 32'h8001BEEF, 1'b0, 1'b0);
        req(0, 1'b1, SZ_W, 1'b0, 12'h011, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0);
        req(0, 1'b0, SZ_H, 1'b0, 12'h013, 32'h0, 32'h0, 1'b1, 1'b0);
        req(0, 1'b1, SZ_X, 1'b0, 12'h010, 32'h11111111, 32'h0, 1'b1, 1'b0);
        req(0, 1'b0, SZ_W, 1'b0, 12'h010, 32'h0, 32'h8001BEEF, 1'b0, 1'b0);

        // WAIT_STATES=0 instance
        req(1, 1'b1, SZ_W, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        req(1, 1'b1, SZ_W, 1'b0, 12'h011, 32'h01234567, 32'h0, 1'b1, 1'b0);
        req(1, 1'b0, SZ_H, 1'b0, 12'h013, 32'h0, 32'h0, 1'b1, 1'b0);
        req(1, 1'b0, SZ_W, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        req(1, 1'b0, SZ_B, 1'b0, 12'h011, 32'h0, 32'hFFFFFFBE, 1'b0, 1'b0);
        req(1, 1'b0, SZ_H, 1'b1, 12'h012, 32'h0, 32'h0000DEAD, 1'b0, 1'b0);

        // Store aborted by reset during WAIT leaves the word untouched
        req(0, 1'b1, SZ_W, 1'b0, 12'h020, 32'h0, 32'h0, 1'b0, 1'b0);
        wait_ready(0);
        req_we[0] = 1'b1; req_size[0] = SZ_W; req_addr[0] = 12'h020;
        req_wdata[0] = 32'h12345678; req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("abort_ready", 32'(req_ready[0]), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_abort_ready", 32'(req_ready[0]), 32'd1);
        req(0, 1'b0, SZ_W, 1'b0, 12'h020, 32'h0, 32'h00000000, 1'b0, 1'b0);

        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (q0.size() > 0) begin
            void'(q0.pop_front());
            check("missing_rsp_dut0", 32'd0, 32'd1);
        end
        while (q1.size() > 0) begin
            void'(q1.pop_front());
            check("missing_rsp_dut1", 32'd0, 32'd1);
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
